// File: rtl/stall_pipe_pkg.sv
// Shared constants, instruction classes and stage record for the stall pipeline.
package stall_pipe_pkg;

  localparam logic [31:0] DEF_PC_RESET = 32'h0000_3000;
  localparam logic [31:0] DEF_NOP      = '0;
  localparam logic [4:0]  REG_RA       = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_CAL_R,
    CLS_CAL_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_JR,
    CLS_JAL
  } instr_cls_e;

  typedef struct packed {
    instr_cls_e cls;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wdst;
  } instr_info_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } stage_t;

  // A read only conflicts when enabled, not $0, and aimed at the writer's destination.
  function automatic logic reg_hit(input logic en, input logic [4:0] r, input logic [4:0] dst);
    return en && (r != 5'd0) && (r == dst);
  endfunction

endpackage

// File: rtl/stall_pipe_if.sv
// Fetch-side inputs and per-stage observation outputs of the stall pipeline.
interface stall_pipe_if;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] INS_D, INS_E, INS_M, INS_W;
  logic [31:0] PC_D, PC_E, PC_M, PC_W;
  logic        stall;
  logic [15:0] stall_cnt;
  logic [15:0] retire_cnt;

  modport master (
    output instr_f, pc_f,
    input  INS_D, INS_E, INS_M, INS_W, PC_D, PC_E, PC_M, PC_W,
    input  stall, stall_cnt, retire_cnt
  );

  modport slave (
    input  instr_f, pc_f,
    output INS_D, INS_E, INS_M, INS_W, PC_D, PC_E, PC_M, PC_W,
    output stall, stall_cnt, retire_cnt
  );
endinterface

// File: rtl/stall_pipe_instr_class.sv
// Decodes one instruction word into its class, source registers and write destination.
module instr_class
  import stall_pipe_pkg::*;
(
  input  logic [31:0] instr,
  output instr_info_t info
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_shamt;

  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    info.cls  = CLS_NOP;
    info.rs   = instr[25:21];
    info.rt   = instr[20:16];
    info.wdst = 5'd0;
    unique case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU || funct == FN_SUBU) begin
          info.cls  = CLS_CAL_R;
          info.wdst = instr[15:11];
        end else if (funct == FN_JR) begin
          info.cls = CLS_JR;
        end
      end
      OP_ORI, OP_LUI: begin
        info.cls  = CLS_CAL_I;
        info.wdst = instr[20:16];
      end
      OP_LW: begin
        info.cls  = CLS_LOAD;
        info.wdst = instr[20:16];
      end
      OP_SW:   info.cls = CLS_STORE;
      OP_BEQ:  info.cls = CLS_BEQ;
      OP_JAL: begin
        info.cls  = CLS_JAL;
        info.wdst = REG_RA;
      end
      default: info.cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/stall_pipe.sv
// D/E/M/W instruction+PC pipeline with load-use and branch-operand interlock,
// plus saturating stall and retire counters.
module stall_pipe
  import stall_pipe_pkg::*;
#(
  parameter logic [31:0] PC_RESET = DEF_PC_RESET,
  parameter logic [31:0] NOP      = DEF_NOP
) (
  input  logic        clk,
  input  logic        reset,
  stall_pipe_if.slave bus
);

  stage_t      dec_q, dec_d, exe_q, exe_d, mem_q, mem_d, wb_q, wb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, retire_cnt_q, retire_cnt_d;
  instr_info_t info_d, info_e, info_m;
  logic        early_rs, early_rt, alu_rs, alu_rt;
  logic        hz_e_wr, hz_m_ld, hz_e_ld, stall;
  logic        unused_info;

  instr_class u_class_d (.instr(dec_q.ins), .info(info_d));
  instr_class u_class_e (.instr(exe_q.ins), .info(info_e));
  instr_class u_class_m (.instr(mem_q.ins), .info(info_m));

  assign unused_info = ^{info_d.wdst, info_e.rs, info_e.rt, info_m.rs, info_m.rt};

  always_comb begin
    early_rs = info_d.cls inside {CLS_BEQ, CLS_JR};
    early_rt = (info_d.cls == CLS_BEQ);
    alu_rs   = info_d.cls inside {CLS_CAL_R, CLS_CAL_I, CLS_LOAD, CLS_STORE};
    alu_rt   = (info_d.cls == CLS_CAL_R);
    // Non-writers decode wdst=0, so reg_hit rejects them without a class test.
    hz_e_wr  = reg_hit(early_rs, info_d.rs, info_e.wdst) ||
               reg_hit(early_rt, info_d.rt, info_e.wdst);
    hz_m_ld  = (info_m.cls == CLS_LOAD) &&
               (reg_hit(early_rs, info_d.rs, info_m.wdst) ||
                reg_hit(early_rt, info_d.rt, info_m.wdst));
    hz_e_ld  = (info_e.cls == CLS_LOAD) &&
               (reg_hit(alu_rs, info_d.rs, info_e.wdst) ||
                reg_hit(alu_rt, info_d.rt, info_e.wdst));
    stall    = hz_e_wr || hz_m_ld || hz_e_ld;
  end

  always_comb begin
    dec_d = stall ? dec_q : '{ins: bus.instr_f, pc: bus.pc_f};
    exe_d = stall ? '{ins: NOP, pc: dec_q.pc} : dec_q;
    mem_d = exe_q;
    wb_d  = mem_q;
    stall_cnt_d  = stall_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 16'd1;
    if (wb_q.ins != NOP && retire_cnt_q != '1) retire_cnt_d = retire_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dec_q        <= '{ins: NOP, pc: PC_RESET};
      exe_q        <= '{ins: NOP, pc: PC_RESET};
      mem_q        <= '{ins: NOP, pc: PC_RESET};
      wb_q         <= '{ins: NOP, pc: PC_RESET};
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      dec_q        <= dec_d;
      exe_q        <= exe_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      stall_cnt_q  <= stall_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.INS_D      = dec_q.ins;
  assign bus.INS_E      = exe_q.ins;
  assign bus.INS_M      = mem_q.ins;
  assign bus.INS_W      = wb_q.ins;
  assign bus.PC_D       = dec_q.pc;
  assign bus.PC_E       = exe_q.pc;
  assign bus.PC_M       = mem_q.pc;
  assign bus.PC_W       = wb_q.pc;
  assign bus.stall      = stall;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: doc/stall_pipe.md
STALL_PIPE -- requirements
Module: stall_pipe

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000, reset value of every stage PC register.
REQ-002 Parameter NOP, default 32'h0000_0000, instruction word used for bubbles and reset.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 instr_f  in  32  instruction fetched at pc_f.
REQ-006 pc_f  in  32  fetch-stage PC.
REQ-007 INS_D / INS_E / INS_M / INS_W  out  32 each  registered instruction in each stage; feed the forwarding unit.
REQ-008 PC_D / PC_E / PC_M / PC_W  out  32 each  registered PC of each stage.
REQ-009 stall  out  1  combinational; high freezes PC and the F/D register.
REQ-010 stall_cnt  out  16  registered count of stall cycles, saturating.
REQ-011 retire_cnt  out  16  registered count of non-NOP instructions leaving W, saturating.

Function
REQ-012 Supported classes: cal_r (addu, subu), cal_i (ori, lui), load (lw), store (sw), beq, jr, jal; any other word is treated as a NOP that neither reads nor writes registers.
REQ-013 Write destination: cal_r uses rd, cal_i and load use rt, jal uses 5'd31; destination 0 counts as no write.
REQ-014 Early-read set of D: beq reads rs and rt; jr reads rs.
REQ-015 ALU-read set of D: cal_r reads rs and rt; cal_i, load and store read rs; store rt is excluded, because it is covered by forwarding at E/M.
REQ-016 stall SHALL be 1 when an early-read register of D is nonzero and equals the write destination of E, for any writer class.
REQ-017 stall SHALL be 1 when an early-read register of D is nonzero and equals the write destination of a load in M.
REQ-018 stall SHALL be 1 when an ALU-read register of D is nonzero and equals the write destination of a load in E.
REQ-019 In every other case, stall SHALL be 0.
REQ-020 Non-stall edge: D<-(instr_f, pc_f), E<-D, M<-E, W<-M, with the instruction and PC of each stage moving together.
REQ-021 Stall edge: D holds; E<-(NOP, PC_D); M<-E; W<-M. M and W always advance.
REQ-022 Latency: an instruction accepted at the F/D edge appears on INS_W exactly 3 cycles later plus one cycle per stall it incurs.
REQ-023 No flush path exists: the branch delay slot always executes, and no input kills an in-flight instruction.
REQ-024 stall_cnt SHALL increment by 1 on each edge where stall=1, and SHALL hold at 16'hFFFF once reached.
REQ-025 retire_cnt SHALL increment by 1 on each edge where INS_W != NOP, and SHALL hold at 16'hFFFF once reached.
REQ-026 When several stall conditions hold at once, the block inserts exactly one bubble per cycle, and the cycles repeat until no condition holds.

Reset
REQ-027 On an edge with reset=0: all INS_* = NOP, all PC_* = PC_RESET, stall_cnt = 0, retire_cnt = 0.
REQ-028 Reset takes priority over stall and advance, including when it is asserted mid-stall.
REQ-029 While reset=0, stall SHALL read 0 on the cycle after the reset edge, because all stages then hold NOP.

Structure
REQ-030 A shared package holds the opcode/funct constants, PC_RESET, NOP and the register-31 constant.
REQ-031 One sub-module, instr_class, decodes a 32-bit word into class flags, rs, rt and write destination.
REQ-032 instr_class is instantiated three times: for D, E and M.

Verification
REQ-033 lw $1,0($0) then addu $2,$1,$1 -> one stall cycle, a NOP in E on that cycle, stall_cnt=1, and addu reaches W two cycles after lw.
REQ-034 ori $3,$0,5 then beq $3,$0 -> one stall (writer in E); with beq behind lw $3 -> two stalls in total (E-load, then M-load).
REQ-035 jal then jr $31 in the delay slot -> one stall; in the following cycle, INS_M=jal and INS_D=jr with no stall.
REQ-036 lw $4 then sw $4,0($0) -> no stall, and sw follows lw by exactly one cycle in every stage.
REQ-037 reset=0 asserted during a stall cycle -> on the next edge all INS_*=0, all PC_*=0x3000, counters=0 and stall=0.
REQ-038 Counter boundary: force 65535 stall cycles -> stall_cnt=16'hFFFF, and it stays 16'hFFFF after further stalls.
